// File: rtl/bsg_clk_gen_pearl_pkg.sv
// Shared types for the clock-gen pearl monitor path.
package bsg_clk_gen_pearl_pkg;

  // Measurement sequencing of the monitor counter.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } bsg_clk_gen_pearl_monitor_counter_state_e;

  // Stages between the asynchronous monitor pin and the edge history flop.
  localparam int unsigned monitor_sync_stages_lp = 2;

endpackage

// File: rtl/bsg_clk_gen_pearl_monitor_edge_sync.sv
// Brings an asynchronous monitor clock into clk_i and flags its rising edges.
module bsg_clk_gen_pearl_monitor_edge_sync
  import bsg_clk_gen_pearl_pkg::*;
(
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic monitor,
  output logic rise_c
);

  (* async_reg = "true" *) logic [monitor_sync_stages_lp-1:0] sync_r;
  logic hist_r;

  // Two-stage synchronizer followed by one history flop for edge detection.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_r <= '0;
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[monitor_sync_stages_lp-2:0], monitor};
      hist_r <= sync_r[monitor_sync_stages_lp-1];
    end
  end

  // Single-cycle pulse when the synchronized monitor goes 0 -> 1.
  assign rise_c = sync_r[monitor_sync_stages_lp-1] & ~hist_r;

endmodule

// File: rtl/bsg_clk_gen_pearl_monitor_counter.sv
// Counts monitor-clock rising edges over a programmable window of clk_i cycles.
module bsg_clk_gen_pearl_monitor_counter
  import bsg_clk_gen_pearl_pkg::*;
#(
  parameter int unsigned window_width_p = 16,
  parameter int unsigned count_width_p  = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      clk_monitor_i,
  input  logic                      start_v_i,
  input  logic [window_width_p-1:0] window_i,
  output logic                      ready_o,
  output logic                      count_v_o,
  output logic [count_width_p-1:0]  count_o,
  output logic                      overflow_o,
  input  logic                      yumi_i
);

  bsg_clk_gen_pearl_monitor_counter_state_e state_r, state_n;

  logic [window_width_p-1:0] win_r, win_n;
  logic [count_width_p-1:0]  count_r, count_n;
  logic                      overflow_r, overflow_n;
  logic                      ready_r, ready_n;
  logic                      count_v_r, count_v_n;
  logic                      rise;

  bsg_clk_gen_pearl_monitor_edge_sync edge_sync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .monitor   (clk_monitor_i),
    .rise_c    (rise)
  );

  // Next-state, window/count update and output decode.
  always_comb begin
    state_n    = state_r;
    win_n      = win_r;
    count_n    = count_r;
    overflow_n = overflow_r;
    unique case (state_r)
      IDLE: begin
        if (start_v_i && ready_r) begin
          count_n    = '0;
          overflow_n = 1'b0;
          if (window_i != '0) begin
            win_n   = window_i;
            state_n = MEASURE;
          end else begin
            state_n = DONE;
          end
        end
      end
      MEASURE: begin
        win_n = win_r - window_width_p'(1);
        if (rise) begin
          if (count_r == '1) overflow_n = 1'b1;
          else               count_n    = count_r + count_width_p'(1);
        end
        if (win_r == window_width_p'(1)) state_n = DONE;
      end
      DONE: begin
        if (yumi_i && count_v_r) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    ready_n   = (state_n == IDLE);
    // Valid trails entry to DONE by one cycle and drops on the taking edge.
    count_v_n = (state_r == DONE) && !(count_v_r && yumi_i);
  end

  // State and datapath registers; reset discards any partial measurement.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= IDLE;
      win_r      <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      ready_r    <= 1'b1;
      count_v_r  <= 1'b0;
    end else begin
      state_r    <= state_n;
      win_r      <= win_n;
      count_r    <= count_n;
      overflow_r <= overflow_n;
      ready_r    <= ready_n;
      count_v_r  <= count_v_n;
    end
  end

  assign ready_o    = ready_r;
  assign count_v_o  = count_v_r;
  assign count_o    = count_r;
  assign overflow_o = overflow_r;

endmodule

// File: tb/tb_bsg_clk_gen_pearl_monitor_counter.sv
// Directed bench for the monitor edge counter (16-bit and 4-bit count instances).
module tb_bsg_clk_gen_pearl_monitor_counter;

  logic        clk;
  logic        reset_n;
  logic        mon;
  logic        start, start4;
  logic [15:0] window, window4;
  logic        yumi, yumi4;
  logic        ready, ready4;
  logic        count_v, count_v4;
  logic [15:0] count;
  logic [3:0]  count4;
  logic        ovf, ovf4;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int mon_per   = 0;
  logic mon_lvl = 1'b0;

  bsg_clk_gen_pearl_monitor_counter dut (
    .clk_i(clk), .reset_n_i(reset_n), .clk_monitor_i(mon),
    .start_v_i(start), .window_i(window), .ready_o(ready),
    .count_v_o(count_v), .count_o(count), .overflow_o(ovf), .yumi_i(yumi)
  );

  bsg_clk_gen_pearl_monitor_counter #(.window_width_p(16), .count_width_p(4)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n), .clk_monitor_i(mon),
    .start_v_i(start4), .window_i(window4), .ready_o(ready4),
    .count_v_o(count_v4), .count_o(count4), .overflow_o(ovf4), .yumi_i(yumi4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor clock: square wave of mon_per clk_i cycles, or a held level when mon_per is 0.
  initial begin
    int mcnt;
    mcnt = 0;
    mon  = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      mcnt++;
      if (mon_per == 0) mon = mon_lvl;
      else              mon = ((mcnt % mon_per) < (mon_per / 2));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Accept happens at the second posedge; returns just after that edge.
  task automatic do_start(input int w);
    @(posedge clk); #1;
    start  = 1'b1;
    window = 16'(w);
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic take_yumi();
    @(posedge clk); #1;
    check("valid_before_yumi", 32'(count_v), 32'd1);
    yumi = 1'b1;
    @(posedge clk); #1;
    yumi = 1'b0;
    @(negedge clk);
    check("ready_after_yumi", 32'(ready), 32'd1);
    check("valid_after_yumi", 32'(count_v), 32'd0);
  endtask

  task automatic measure(input string tag, input int w, input int lo, input int hi);
    do_start(w);
    @(negedge clk);
    check({tag, "_ready_low"}, 32'(ready), 32'd0);
    repeat (w) @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_early"}, 32'(count_v), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"}, 32'(count_v), 32'd1);
    check({tag, "_count_range"}, 32'((count >= 16'(lo)) && (count <= 16'(hi))), 32'd1);
    check({tag, "_overflow"}, 32'(ovf), 32'd0);
    take_yumi();
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; start4 = 1'b0;
    window = '0;  window4 = '0;
    yumi = 1'b0;  yumi4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(count_v), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(ovf), 32'd0);
    reset_n = 1'b1;

    // Edge every 8 cycles over 800 cycles.
    mon_per = 8;
    repeat (4) @(posedge clk);
    measure("w800", 800, 99, 101);

    // Zero-length window goes straight to a zero result.
    do_start(0);
    @(negedge clk);
    check("w0_valid_early", 32'(count_v), 32'd0);
    check("w0_ready_low", 32'(ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("w0_valid", 32'(count_v), 32'd1);
    check("w0_count", 32'(count), 32'd0);
    check("w0_overflow", 32'(ovf), 32'd0);
    take_yumi();

    // 4-bit counter, edge every 4 cycles for 100 cycles: saturates with overflow.
    mon_per = 4;
    @(posedge clk); #1;
    start4  = 1'b1;
    window4 = 16'd100;
    @(posedge clk); #1;
    start4  = 1'b0;
    repeat (101) @(posedge clk);
    @(negedge clk);
    check("sat_valid", 32'(count_v4), 32'd1);
    check("sat_count", 32'(count4), 32'd15);
    check("sat_overflow", 32'(ovf4), 32'd1);
    @(posedge clk); #1;
    yumi4 = 1'b1;
    @(posedge clk); #1;
    yumi4 = 1'b0;
    @(negedge clk);
    check("sat_ready_after_yumi", 32'(ready4), 32'd1);

    // Asynchronous reset in the middle of a measurement.
    mon_per = 8;
    do_start(80);
    repeat (30) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(count_v), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_overflow", 32'(ovf), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    measure("w80", 80, 9, 11);

    // Single monitor edge, then hold DONE for 50 cycles while pulsing start.
    mon_per = 0;
    mon_lvl = 1'b0;
    repeat (6) @(posedge clk);
    do_start(40);
    repeat (10) @(posedge clk);
    mon_lvl = 1'b1;
    repeat (35) @(posedge clk);
    @(negedge clk);
    check("hold_valid", 32'(count_v), 32'd1);
    check("hold_count", 32'(count), 32'd1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      start  = (i % 2 == 0);
      window = 16'd5;
      @(negedge clk);
      if (i % 10 == 9) begin
        check("hold_count_stable", 32'(count), 32'd1);
        check("hold_ready_low", 32'(ready), 32'd0);
        check("hold_valid_high", 32'(count_v), 32'd1);
      end
    end
    start = 1'b0;
    take_yumi();

    // Fresh start with the monitor stuck high: no edges.
    measure("stuck_high", 1000, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bsg_clk_gen_pearl_monitor_counter.md
# bsg_clk_gen_pearl_monitor_counter

Measurement end of the clock-generator monitor path. Takes the divided monitor clock produced by the clock-gen pearl, which is asynchronous to this block, and synchronizes it into the reference clock domain `clk_i`. It then counts monitor rising edges over a programmable window of `clk_i` cycles and returns the count to the host over a valid/yumi handshake. Sits in the always-on reference domain, one instance per monitored clock; software derives f_gen = count * 30 * f_ref / window.

## Interface
Parameters:
- `window_width_p`, default 16: width of the window length, in `clk_i` cycles.
- `count_width_p`, default 16: width of the edge count.

Ports:
- `clk_i`, in, 1: reference clock; only clock of the block.
- `reset_n_i`, in, 1: reset, asynchronous, active-low.
- `clk_monitor_i`, in, 1: divided monitor clock, asynchronous to `clk_i`.
- `start_v_i`, in, 1: start request; accepted when `start_v_i & ready_o`.
- `window_i`, in, `window_width_p`: window length W in `clk_i` cycles; sampled on accept.
- `ready_o`, out, 1: high in IDLE.
- `count_v_o`, out, 1: result valid.
- `count_o`, out, `count_width_p`: monitor rising-edge count.
- `overflow_o`, out, 1: count saturated during the window.
- `yumi_i`, in, 1: consumer takes the result; legal only while `count_v_o`.

## Operation
- Synchronizer: two flops on `clk_monitor_i`, followed by one history flop.
  - edge = sync2 & ~hist.
  - All three flops reset to 0.
- FSM states: IDLE, MEASURE, DONE.
- IDLE:
  - `ready_o`=1.
  - On accept with W≠0: load the window down-counter with W, clear count and overflow, go to MEASURE.
  - On accept with W=0: clear count and overflow, go directly to DONE.
- MEASURE:
  - Each cycle, on edge: count+1, saturating at all-ones.
  - An edge arriving while count is all-ones sets `overflow_o`, which is sticky for the measurement.
  - The window counter decrements every cycle; the cycle in which it equals 1 is the last sampled cycle, and the FSM moves to DONE on the next clock.
  - Exactly W cycles are sampled.
- DONE:
  - `count_v_o`=1.
  - `count_o` and `overflow_o` are held stable until `yumi_i`.
  - `yumi_i` returns the FSM to IDLE.
- `start_v_i` is ignored outside IDLE.
- `yumi_i` without `count_v_o` is ignored; the bench asserts it never occurs.
- The synchronizer runs continuously, so an edge already in flight when a measurement starts may be counted. The measurement error is ±1 edge.
- Reset (asynchronous, any state):
  - FSM→IDLE.
  - All counters, synchronizer flops and `overflow_o` → 0.
  - `ready_o`=1, `count_v_o`=0, `count_o`=0.
  - Any partial measurement is discarded.

## Timing
- Accept at rising edge N. Cycles N+1..N+W are sampled.
- `count_v_o` rises after edge N+W+1.
- For W=0, `count_v_o` rises after edge N+1.
- `ready_o` falls after edge N and rises one cycle after the `yumi_i` edge.
- Synchronizer latency: 2–3 `clk_i` cycles from a monitor edge to the edge pulse.
- Monitor requirement: high and low phases each ≥ 1.5 `clk_i` periods, i.e. f_monitor ≤ f_clk/3. Faster clocks undercount; no detection is provided.
- The only asynchronous input is `clk_monitor_i`. The sync flops carry the codebase's synchronizer attribute for CDC sign-off.

## Structure
- Package `bsg_clk_gen_pearl_pkg`: state enum `bsg_clk_gen_pearl_monitor_counter_state_e` (IDLE, MEASURE, DONE).
- Sub-module `bsg_clk_gen_pearl_monitor_edge_sync`:
  - Ports: `clk_i`, `reset_n_i`, async input, edge pulse output.
  - Contains the 2-flop synchronizer and history flop; reusable by other pearl CDC monitors.
- Top level contains the FSM, window down-counter and saturating edge counter.

## Test plan
- Monitor rising edge every 8 `clk_i` cycles, W=800 → `count_o`=100±1, `overflow_o`=0, `count_v_o` rises at accept+801.
- W=0 → `count_v_o` one cycle after accept, `count_o`=0.
- `count_width_p`=4, edge every 4 cycles, W=100 → `count_o`=15, `overflow_o`=1.
- Hold `yumi_i`=0 for 50 cycles in DONE while pulsing `start_v_i` → `count_o` stable, `ready_o`=0, no new start accepted. Then `yumi_i`=1 → `ready_o`=1 next cycle, and a fresh start works.
- `reset_n_i` low mid-MEASURE, between clock edges → `count_v_o`=0, `count_o`=0, `ready_o`=1 immediately. After release, W=80 with edge every 8 cycles → `count_o`=10±1.
- `clk_monitor_i` held constant at 1, W=1000 → `count_o`=0.
